// File: rtl/mem_access_unit_if.sv
// Data-bus interface of the memory-stage load/store unit: one registered
// request held until a single-cycle ack strobe from the slave.
interface mem_access_unit_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    // Handshake: master raises dbus_req with addr/we/wdata/be stable and keeps
    // them unchanged until the cycle in which the slave pulses dbus_ack (which
    // also qualifies dbus_rdata); an ack seen while dbus_req is low is ignored.
    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_rdata, dbus_ack
    );
    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: IDLE/REQ/DONE bus transaction with pipeline stall,
// load extraction and bus timeout. Optional macro MEM_MISALIGN_TRAP_EN traps misaligned H/W.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  Funct3M,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM,
    output logic [1:0]  dbg_state_o,
    mem_access_unit_if.master dbus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   data_q;
    logic          buserr_q;

    logic          access;
    logic          is_b, is_h, is_w;
    logic [1:0]    eff_lo;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [31:0]   lane_word;
    logic [31:0]   ext;
    logic          timeout_hit;
    logic          trap_now;

    assign access = MemReadM | MemWriteM;
    assign is_b   = (Funct3M[1:0] == 2'b00);
    assign is_h   = (Funct3M[1:0] == 2'b01);
    assign is_w   = ~is_b & ~is_h;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap_now = (is_h & ALUResultM[0]) | (is_w & (ALUResultM[1:0] != 2'b00));
`else
    assign trap_now = 1'b0;
`endif

    // Offending low bits are dropped so an unaligned H/W lands on its containing lane group.
    always_comb begin
        eff_lo = ALUResultM[1:0];
        if (is_h)      eff_lo[0] = 1'b0;
        else if (is_w) eff_lo    = 2'b00;
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM;
        if (is_b) begin
            be_calc    = 4'b0001 << eff_lo;
            wdata_calc = {4{WriteDataM[7:0]}};
        end else if (is_h) begin
            be_calc    = 4'b0011 << {eff_lo[1], 1'b0};
            wdata_calc = {2{WriteDataM[15:0]}};
        end
    end

    always_comb begin
        lane_word = dbus.dbus_rdata >> {lane_q, 3'b000};
        unique case (f3_q[1:0])
            2'b00:   ext = f3_q[2] ? {24'b0, lane_word[7:0]}
                                   : {{24{lane_word[7]}}, lane_word[7:0]};
            2'b01:   ext = f3_q[2] ? {16'b0, lane_word[15:0]}
                                   : {{16{lane_word[15]}}, lane_word[15:0]};
            default: ext = dbus.dbus_rdata;
        endcase
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (access) state_d = trap_now ? S_DONE : S_REQ;
            S_REQ:   if (dbus.dbus_ack || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        StallM    = 1'b0;
        BusErrM   = 1'b0;
        MisalignM = 1'b0;
        unique case (state_q)
            S_IDLE: StallM = access;
            S_REQ:  StallM = 1'b1;
            S_DONE: begin
                BusErrM = buserr_q;
`ifdef MEM_MISALIGN_TRAP_EN
                MisalignM = misalign_q;
`endif
            end
            default: StallM = 1'b0;
        endcase
        if (reset) StallM = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            lane_q   <= '0;
            f3_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            buserr_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: if (access) begin
                    cnt_q    <= '0;
                    buserr_q <= 1'b0;
                    data_q   <= '0;
                    lane_q   <= eff_lo;
                    f3_q     <= Funct3M;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_q <= trap_now;
`endif
                    if (!trap_now) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWriteM;
                        addr_q  <= {ALUResultM[31:2], 2'b00};
                        be_q    <= be_calc;
                        wdata_q <= wdata_calc;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (dbus.dbus_ack) begin
                        req_q  <= 1'b0;
                        data_q <= ext;
                    end else if (timeout_hit) begin
                        req_q    <= 1'b0;
                        buserr_q <= 1'b1;
                        data_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ReadDataM       = data_q;
    assign dbg_state_o     = state_q;
    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wdata = wdata_q;
    assign dbus.dbus_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit; the bench plays the bus slave
// and scoreboards load data through exp_q.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  Funct3M;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM, MisalignM;
    logic [1:0]  dbg_state;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .Funct3M    (Funct3M),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BusErrM    (BusErrM),
        .MisalignM  (MisalignM),
        .dbg_state_o(dbg_state),
        .dbus       (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << a;
            3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * a);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return rd;
        endcase
    endfunction

    // One M-stage access; ack_wait < 0 means the slave never answers.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input int ack_wait,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input int exp_stall, input int exp_reqc,
                              input logic exp_err, input logic exp_mis);
        int stalls, reqc;
        bit done;
        logic [31:0] exp_data;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wd; Funct3M = f3;
        stalls = 0; reqc = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            bus.dbus_ack = 1'b0;
            #1;
            if (dbg_state == 2'd2) begin
                done = 1;
                chk($sformatf("%s/stall_in_done", tag), {31'b0, StallM}, 32'd0);
                chk($sformatf("%s/stall_cycles", tag), stalls, exp_stall);
                chk($sformatf("%s/req_cycles", tag), reqc, exp_reqc);
                chk($sformatf("%s/buserr", tag), {31'b0, BusErrM}, {31'b0, exp_err});
                chk($sformatf("%s/misalign", tag), {31'b0, MisalignM}, {31'b0, exp_mis});
                if (rd) begin
                    exp_data = exp_q.pop_front();
                    chk($sformatf("%s/rdata", tag), ReadDataM, exp_data);
                end
                MemReadM = 1'b0; MemWriteM = 1'b0;
            end else begin
                if (StallM) stalls++;
                if (bus.dbus_req) begin
                    reqc++;
                    if (reqc == 1) begin
                        chk($sformatf("%s/addr", tag), bus.dbus_addr, exp_addr);
                        chk($sformatf("%s/be", tag), {28'b0, bus.dbus_be}, {28'b0, exp_be});
                        chk($sformatf("%s/we", tag), {31'b0, bus.dbus_we}, {31'b0, wr});
                        if (wr) chk($sformatf("%s/wdata", tag), bus.dbus_wdata, exp_wdata);
                    end
                    if (reqc == ack_wait + 1) begin
                        bus.dbus_ack   = 1'b1;
                        bus.dbus_rdata = rdata;
                    end
                end
            end
            @(negedge clk);
        end
        bus.dbus_ack = 1'b0;
        if (!done) chk($sformatf("%s/done_reached", tag), 32'd0, 32'd1);
        #1;
        chk($sformatf("%s/back_idle", tag), {30'b0, dbg_state}, 32'd0);
        chk($sformatf("%s/stall_after", tag), {31'b0, StallM}, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3_tab [5];
        logic [2:0]  f3;
        logic [1:0]  lane;
        logic [31:0] a, rd;
        int          w;
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = '0; WriteDataM = '0; Funct3M = '0;
        bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset/state", {30'b0, dbg_state}, 32'd0);
        chk("reset/req", {31'b0, bus.dbus_req}, 32'd0);
        chk("reset/stall", {31'b0, StallM}, 32'd0);
        chk("reset/rdata", ReadDataM, 32'd0);
        chk("reset/addr", bus.dbus_addr, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("nomem/stall", {31'b0, StallM}, 32'd0);
            chk("nomem/state", {30'b0, dbg_state}, 32'd0);
        end

        exp_q.push_back(32'hDEADBEEF);
        run_access("lw_100", 1, 0, 32'h100, 0, 3'b010, 0, 32'hDEADBEEF,
                   32'h100, 4'b1111, 0, 2, 1, 0, 0);
        exp_q.push_back(32'hFFFFFF80);
        run_access("lb_203", 1, 0, 32'h203, 0, 3'b000, 0, 32'h80000000,
                   32'h200, 4'b1000, 0, 2, 1, 0, 0);
        exp_q.push_back(32'h00000080);
        run_access("lbu_203", 1, 0, 32'h203, 0, 3'b100, 0, 32'h80000000,
                   32'h200, 4'b1000, 0, 2, 1, 0, 0);
        run_access("sh_402", 0, 1, 32'h402, 32'h1234ABCD, 3'b001, 3, 32'h0,
                   32'h400, 4'b1100, 32'hABCDABCD, 5, 4, 0, 0);
        exp_q.push_back(32'h0);
        run_access("timeout", 1, 0, 32'h500, 0, 3'b010, -1, 32'h0,
                   32'h500, 4'b1111, 0, 17, 16, 1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        exp_q.push_back(32'h0);
        run_access("lw_101", 1, 0, 32'h101, 0, 3'b010, 0, 32'h11223344,
                   32'h0, 4'b0, 0, 1, 0, 0, 1);
`else
        exp_q.push_back(32'h11223344);
        run_access("lw_101", 1, 0, 32'h101, 0, 3'b010, 0, 32'h11223344,
                   32'h100, 4'b1111, 0, 2, 1, 0, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            f3 = f3_tab[$urandom_range(0, 4)];
            lane = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) lane[0] = 1'b0;
            else if (f3[1:0] == 2'b10) lane = 2'b00;
            a  = ($urandom & 32'hFFFF_FFFC) | {30'b0, lane};
            rd = $urandom;
            w  = $urandom_range(0, 3);
            exp_q.push_back(model_ld(f3, lane, rd));
            run_access($sformatf("rand%0d", i), 1, 0, a, 0, f3, w, rd,
                       {a[31:2], 2'b00}, model_be(f3, lane), 0, 2 + w, 1 + w, 0, 0);
        end

        @(negedge clk);
        MemReadM = 1'b1; ALUResultM = 32'h300; Funct3M = 3'b010;
        @(negedge clk); #1;
        chk("rst_mid/in_req", {30'b0, dbg_state}, 32'd1);
        chk("rst_mid/req_hi", {31'b0, bus.dbus_req}, 32'd1);
        reset = 1'b1; MemReadM = 1'b0;
        #1;
        chk("rst_mid/req", {31'b0, bus.dbus_req}, 32'd0);
        chk("rst_mid/stall", {31'b0, StallM}, 32'd0);
        chk("rst_mid/state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0; bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.dbus_ack = 1'b0;
        #1;
        chk("late_ack/state", {30'b0, dbg_state}, 32'd0);
        chk("late_ack/rdata", ReadDataM, 32'd0);
        chk("late_ack/stall", {31'b0, StallM}, 32'd0);
        chk("scoreboard/empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
